// File: rtl/ctrl_encoder.sv
// Encodes R-format/ld/sd/beq requests into 32-bit instruction words and
// queues them with a PC tag in a small FIFO; a redirect flushes the queue.
module ctrl_encoder #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic        req_sub,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [11:0] req_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [15:0] issue_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [31:0] r_instr_mem [FIFO_DEPTH];
   logic [31:0] r_pc_mem    [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [31:0]   r_pc;
   logic [15:0]   r_issue_cnt;

   logic [31:0] w_instr;
   logic        w_empty;
   logic        w_full;
   logic        w_push;
   logic        w_pop;

   always_comb begin
      w_instr = 32'h0;
      case (req_op)
         2'b00: w_instr = {(req_sub ? 7'b0100000 : 7'b0000000), req_rs2, req_rs1,
                           3'b000, req_rd, 7'b0110011};
         2'b01: w_instr = {req_imm, req_rs1, 3'b011, req_rd, 7'b0000011};
         2'b10: w_instr = {req_imm[11:5], req_rs2, req_rs1, 3'b011,
                           req_imm[4:0], 7'b0100011};
         2'b11: w_instr = {req_imm[11], req_imm[9:4], req_rs2, req_rs1, 3'b000,
                           req_imm[3:0], req_imm[10], 7'b1100011};
         default: w_instr = 32'h0;
      endcase
   end

   // Count never exceeds FIFO_DEPTH (a power of two), so its MSB marks full.
   assign w_empty   = (r_count == '0);
   assign w_full    = r_count[AW];
   assign req_ready = !w_full && !redirect_valid;
   assign out_valid = !w_empty && !redirect_valid;
   assign w_push    = req_valid && req_ready;
   assign w_pop     = out_valid && out_ready;
   assign out_instr = w_empty ? 32'h0 : r_instr_mem[r_rd_ptr];
   assign out_pc    = w_empty ? 32'h0 : r_pc_mem[r_rd_ptr];
   assign issue_cnt = r_issue_cnt;

   // Storage carries no reset; validity is tracked entirely by r_count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr_mem[r_wr_ptr] <= w_instr;
         r_pc_mem[r_wr_ptr]    <= r_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_pc        <= PC_RESET;
         r_issue_cnt <= 16'h0;
      end else if (redirect_valid) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_pc     <= redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_pc     <= r_pc + 32'd4;
         end
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + AW'(1);
            r_issue_cnt <= r_issue_cnt + 16'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
